// File: rtl/sdc_pkg.sv
// Shared register map, response codes, event bits and sequencer states
// for the sdc_controller register-port command path.
package sdc_pkg;

  localparam logic [7:0] ADDR_ARGUMENT   = 8'h00;
  localparam logic [7:0] ADDR_COMMAND    = 8'h04;
  localparam logic [7:0] ADDR_RESPONSE_0 = 8'h08;
  localparam logic [7:0] ADDR_RESPONSE_1 = 8'h0C;
  localparam logic [7:0] ADDR_RESPONSE_2 = 8'h10;
  localparam logic [7:0] ADDR_RESPONSE_3 = 8'h14;
  localparam logic [7:0] ADDR_CMD_EVT    = 8'h34;

  localparam logic [1:0] RSP_NONE    = 2'b00;
  localparam logic [1:0] RSP_48      = 2'b01;
  localparam logic [1:0] RSP_136     = 2'b10;
  localparam logic [1:0] RSP_48_BUSY = 2'b11;

  localparam int EVT_CC   = 0;
  localparam int EVT_EI   = 1;
  localparam int EVT_CTE  = 2;
  localparam int EVT_CCRC = 3;
  localparam int EVT_CIE  = 4;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_WR_ARG,
    SEQ_WR_CMD,
    SEQ_POLL,
    SEQ_RSP,
    SEQ_CLR,
    SEQ_DONE
  } seq_state_t;

  // Busy responses are a 48-bit response plus the busy-wait bit.
  function automatic logic [31:0] buildCmdWord(input logic [5:0] idx,
                                               input logic [1:0] rspType,
                                               input logic [1:0] flags);
    logic [31:0] word;
    word       = 32'h0;
    word[13:8] = idx;
    word[4]    = flags[1];
    word[3]    = flags[0];
    word[2]    = (rspType == RSP_48_BUSY);
    word[1:0]  = (rspType == RSP_48_BUSY) ? RSP_48 : rspType;
    return word;
  endfunction

endpackage

// File: rtl/wb_single_master.sv
// Single-transfer classic Wishbone master: a request launches one cycle,
// the ack and read data are handed straight back on the completing edge.
module wb_single_master (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [7:0]  i_adr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  // A request is only taken while idle, which forces one idle cycle between transfers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= 4'h0;
      wb_adr_o <= 8'h0;
      wb_dat_o <= 32'h0;
    end else if (wb_stb_o) begin
      if (wb_ack_i) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
        wb_sel_o <= 4'h0;
      end
    end else if (i_req) begin
      wb_cyc_o <= 1'b1;
      wb_stb_o <= 1'b1;
      wb_we_o  <= i_we;
      wb_sel_o <= 4'hF;
      wb_adr_o <= i_adr;
      wb_dat_o <= i_wdata;
    end
  end

  assign o_ack   = wb_stb_o & wb_ack_i;
  assign o_rdata = wb_dat_i;

endmodule

// File: rtl/sdc_cmd_sequencer.sv
// Runs one SD command through the sdc_controller register port:
// argument, command, status poll, response readout, status clear.
module sdc_cmd_sequencer
  import sdc_pkg::*;
#(
  parameter int POLL_LIMIT = 65535
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   cmd_rsp_type,
  input  logic [1:0]   cmd_flags,
  output logic         done,
  output logic [127:0] rsp,
  output logic [4:0]   evt_status,
  output logic         timeout,
  output logic [7:0]   wb_adr_o,
  output logic [31:0]  wb_dat_o,
  input  logic [31:0]  wb_dat_i,
  output logic [3:0]   wb_sel_o,
  output logic         wb_we_o,
  output logic         wb_cyc_o,
  output logic         wb_stb_o,
  input  logic         wb_ack_i
);

  localparam int CNT_W = $clog2(POLL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_LIMIT - 1);

  seq_state_t       r_state, w_next;
  logic [5:0]       r_index;
  logic [31:0]      r_arg;
  logic [1:0]       r_rspType;
  logic [1:0]       r_flags;
  logic [CNT_W-1:0] r_pollCnt;
  logic [1:0]       r_rspIdx;
  logic [127:0]     r_rsp;
  logic [4:0]       r_evt;
  logic             r_timeout;

  logic             w_req;
  logic             w_we;
  logic [7:0]       w_adr;
  logic [31:0]      w_wdata;
  logic             w_ack;
  logic [31:0]      w_rdata;
  logic             w_evtHit;

  assign w_evtHit = |w_rdata[4:0];

  wb_single_master u_master (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req    (w_req),
    .i_we     (w_we),
    .i_adr    (w_adr),
    .i_wdata  (w_wdata),
    .o_ack    (w_ack),
    .o_rdata  (w_rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i)
  );

  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_we    = 1'b0;
    w_adr   = 8'h0;
    w_wdata = 32'h0;
    case (r_state)
      SEQ_IDLE: begin
        if (cmd_valid) w_next = SEQ_WR_ARG;
      end
      SEQ_WR_ARG: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_adr   = ADDR_ARGUMENT;
        w_wdata = r_arg;
        if (w_ack) w_next = SEQ_WR_CMD;
      end
      SEQ_WR_CMD: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_adr   = ADDR_COMMAND;
        w_wdata = buildCmdWord(r_index, r_rspType, r_flags);
        if (w_ack) w_next = SEQ_POLL;
      end
      SEQ_POLL: begin
        w_req = 1'b1;
        w_adr = ADDR_CMD_EVT;
        if (w_ack) begin
          if (w_evtHit)
            w_next = (r_rspType != RSP_NONE && w_rdata[EVT_CC]) ? SEQ_RSP : SEQ_CLR;
          else if (r_pollCnt >= CNT_LAST)
            w_next = SEQ_CLR;
        end
      end
      SEQ_RSP: begin
        w_req = 1'b1;
        w_adr = ADDR_RESPONSE_0 + {4'b0000, r_rspIdx, 2'b00};
        if (w_ack && !(r_rspType == RSP_136 && r_rspIdx != 2'd3)) w_next = SEQ_CLR;
      end
      SEQ_CLR: begin
        w_req = 1'b1;
        w_we  = 1'b1;
        w_adr = ADDR_CMD_EVT;
        if (w_ack) w_next = SEQ_DONE;
      end
      SEQ_DONE: w_next = SEQ_IDLE;
      default:  w_next = SEQ_IDLE;
    endcase
  end

  // Command fields are captured once at acceptance; results hold until the next acceptance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= SEQ_IDLE;
      r_index   <= 6'h0;
      r_arg     <= 32'h0;
      r_rspType <= 2'b00;
      r_flags   <= 2'b00;
      r_pollCnt <= '0;
      r_rspIdx  <= 2'd0;
      r_rsp     <= 128'h0;
      r_evt     <= 5'h0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        SEQ_IDLE: begin
          if (cmd_valid) begin
            r_index   <= cmd_index;
            r_arg     <= cmd_arg;
            r_rspType <= cmd_rsp_type;
            r_flags   <= cmd_flags;
            r_pollCnt <= '0;
            r_rspIdx  <= 2'd0;
            r_rsp     <= 128'h0;
            r_evt     <= 5'h0;
            r_timeout <= 1'b0;
          end
        end
        SEQ_WR_CMD: begin
          if (w_ack) r_pollCnt <= '0;
        end
        SEQ_POLL: begin
          if (w_ack) begin
            if (w_evtHit) begin
              r_evt <= w_rdata[4:0];
            end else begin
              if (r_pollCnt != CNT_MAX) r_pollCnt <= r_pollCnt + CNT_W'(1);
              if (r_pollCnt >= CNT_LAST) r_timeout <= 1'b1;
            end
          end
        end
        SEQ_RSP: begin
          if (w_ack) begin
            for (int i = 0; i < 4; i++)
              if (r_rspIdx == 2'(i)) r_rsp[32*i +: 32] <= w_rdata;
            r_rspIdx <= r_rspIdx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready  = (r_state == SEQ_IDLE);
  assign done       = (r_state == SEQ_DONE);
  assign rsp        = r_rsp;
  assign evt_status = r_evt;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_sdc_cmd_sequencer.sv
// Scoreboard bench for sdc_cmd_sequencer: expected bus transfers and results are
// queued by the stimulus, a negedge monitor pops and compares them.
module tb_sdc_cmd_sequencer;
  import sdc_pkg::*;

  localparam int POLL_LIMIT = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   cmd_rsp_type;
  logic [1:0]   cmd_flags;
  logic         done;
  logic [127:0] rsp;
  logic [4:0]   evt_status;
  logic         timeout;
  logic [7:0]   wb_adr_o;
  logic [31:0]  wb_dat_o;
  logic [31:0]  wb_dat_i;
  logic [3:0]   wb_sel_o;
  logic         wb_we_o;
  logic         wb_cyc_o;
  logic         wb_stb_o;
  logic         wb_ack_i;

  always #5 clk = ~clk;

  sdc_cmd_sequencer #(.POLL_LIMIT(POLL_LIMIT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .cmd_rsp_type (cmd_rsp_type),
    .cmd_flags    (cmd_flags),
    .done         (done),
    .rsp          (rsp),
    .evt_status   (evt_status),
    .timeout      (timeout),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_dat_i     (wb_dat_i),
    .wb_sel_o     (wb_sel_o),
    .wb_we_o      (wb_we_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_ack_i     (wb_ack_i)
  );

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;

  // Slave model: status reads walk statusSeq, response reads come from respRegs.
  int          waitStates = 0;
  int          stbCycles = 0;
  int          pollIdx = 0;
  int          pollBase = 0;
  int          pollRel;
  logic [31:0] statusSeq [8];
  logic [31:0] respRegs [4];

  assign wb_ack_i = wb_stb_o && (stbCycles >= waitStates);
  assign pollRel  = (pollIdx - pollBase > 7) ? 7 : (pollIdx - pollBase);

  always_comb begin
    wb_dat_i = 32'h0;
    if (wb_adr_o == ADDR_CMD_EVT)
      wb_dat_i = statusSeq[pollRel];
    else if (wb_adr_o >= ADDR_RESPONSE_0 && wb_adr_o <= ADDR_RESPONSE_3)
      wb_dat_i = respRegs[wb_adr_o[3:2] - 2'd2];
  end

  always @(posedge clk) begin
    cycleCnt = cycleCnt + 1;
    if (wb_stb_o && !wb_ack_i) stbCycles <= stbCycles + 1;
    else                       stbCycles <= 0;
    if (wb_stb_o && wb_ack_i && !wb_we_o && wb_adr_o == ADDR_CMD_EVT)
      pollIdx <= pollIdx + 1;
  end

  typedef struct packed {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
  } txn_t;

  typedef struct packed {
    logic [127:0] rsp;
    logic [4:0]   evt;
    logic         to;
  } res_t;

  txn_t txnQ [$];
  res_t resQ [$];

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushWrite(input logic [7:0] adr, input logic [31:0] dat);
    txn_t t;
    t.we = 1'b1; t.adr = adr; t.dat = dat;
    txnQ.push_back(t);
  endtask

  task automatic pushRead(input logic [7:0] adr);
    txn_t t;
    t.we = 1'b0; t.adr = adr; t.dat = 32'h0;
    txnQ.push_back(t);
  endtask

  task automatic pushResult(input logic [127:0] r, input logic [4:0] e, input logic to);
    res_t x;
    x.rsp = r; x.evt = e; x.to = to;
    resQ.push_back(x);
  endtask

  task automatic setupSlave(input int ws,
                            input logic [31:0] s0, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [31:0] s3,
                            input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] r3);
    waitStates = ws;
    pollBase   = pollIdx;
    statusSeq[0] = s0; statusSeq[1] = s1; statusSeq[2] = s2; statusSeq[3] = s3;
    for (int i = 4; i < 8; i++) statusSeq[i] = 32'h0;
    respRegs[0] = r0; respRegs[1] = r1; respRegs[2] = r2; respRegs[3] = r3;
  endtask

  // Monitor: scoreboard pops on every completed transfer and on every done pulse.
  int   stbLen = 0;
  int   idleLen = 0;
  bit   gapArmed = 0;
  int   doneCount = 0;
  int   doneCycle = 0;
  txn_t expTxn;
  res_t expRes;

  always @(negedge clk) begin
    if (!reset_n) begin
      stbLen   = 0;
      idleLen  = 0;
      gapArmed = 0;
    end else begin
      if (wb_stb_o) begin
        if (stbLen == 0 && gapArmed) checkOutput("busIdleGap", idleLen, 1);
        stbLen++;
        if (wb_ack_i) begin
          checkOutput("stbLength", stbLen, waitStates + 1);
          checkOutput("cycSel", {wb_cyc_o, wb_sel_o}, 5'b11111);
          checkOutput("txnExpected", txnQ.size() != 0, 1);
          if (txnQ.size() != 0) begin
            expTxn = txnQ.pop_front();
            checkOutput("txnWe", wb_we_o, expTxn.we);
            checkOutput("txnAdr", wb_adr_o, expTxn.adr);
            if (expTxn.we) checkOutput("txnWdata", wb_dat_o, expTxn.dat);
          end
          stbLen   = 0;
          idleLen  = 0;
          gapArmed = 1;
        end
      end else begin
        idleLen++;
      end
      if (done) begin
        doneCount++;
        doneCycle = cycleCnt;
        gapArmed  = 0;
        checkOutput("readyWithDone", cmd_ready, 0);
        checkOutput("resultExpected", resQ.size() != 0, 1);
        if (resQ.size() != 0) begin
          expRes = resQ.pop_front();
          checkOutput("rsp", rsp, expRes.rsp);
          checkOutput("evtStatus", evt_status, expRes.evt);
          checkOutput("timeout", timeout, expRes.to);
        end
      end
    end
  end

  int acceptCycle = 0;

  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg,
                               input logic [1:0] rt, input logic [1:0] fl);
    int n = 0;
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_index    = idx;
    cmd_arg      = arg;
    cmd_rsp_type = rt;
    cmd_flags    = fl;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmdAccepted", cmd_ready, 1);
    acceptCycle = cycleCnt;
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
    cmd_index    = 6'h3F;
    cmd_arg      = 32'hFFFF_FFFF;
    cmd_rsp_type = RSP_136;
    cmd_flags    = 2'b11;
  endtask

  task automatic waitDone(input int maxCycles);
    int start = doneCount;
    int n = 0;
    while (doneCount == start && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneSeen", doneCount != start, 1);
    checkOutput("txnQueueDrained", txnQ.size(), 0);
    txnQ.delete();
    resQ.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  int startDone;
  int n;

  initial begin
    reset_n      = 1'b0;
    cmd_valid    = 1'b0;
    cmd_index    = 6'h0;
    cmd_arg      = 32'h0;
    cmd_rsp_type = 2'b00;
    cmd_flags    = 2'b00;
    setupSlave(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetBus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, 0);
    checkOutput("resetResult", {done, timeout, evt_status, rsp}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("readyAfterReset", cmd_ready, 1);

    $display("[TB] CMD8 short response after three polls");
    setupSlave(0, 32'h0, 32'h0, 32'h01, 32'h0, 32'h0000_01AA, 0, 0, 0);
    pushWrite(ADDR_ARGUMENT, 32'h0000_01AA);
    pushWrite(ADDR_COMMAND, 32'h0000_0819);
    pushRead(ADDR_CMD_EVT); pushRead(ADDR_CMD_EVT); pushRead(ADDR_CMD_EVT);
    pushRead(ADDR_RESPONSE_0);
    pushWrite(ADDR_CMD_EVT, 32'h0);
    pushResult(128'h0000_01AA, 5'h01, 1'b0);
    applyStimulus(6'd8, 32'h0000_01AA, RSP_48, 2'b11);
    waitDone(200);

    $display("[TB] CMD2 long response");
    setupSlave(0, 32'h01, 0, 0, 0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    pushWrite(ADDR_ARGUMENT, 32'h0);
    pushWrite(ADDR_COMMAND, 32'h0000_020A);
    pushRead(ADDR_CMD_EVT);
    pushRead(ADDR_RESPONSE_0); pushRead(ADDR_RESPONSE_1);
    pushRead(ADDR_RESPONSE_2); pushRead(ADDR_RESPONSE_3);
    pushWrite(ADDR_CMD_EVT, 32'h0);
    pushResult(128'h4444_4444_3333_3333_2222_2222_1111_1111, 5'h01, 1'b0);
    applyStimulus(6'd2, 32'h0, RSP_136, 2'b01);
    waitDone(200);

    $display("[TB] CMD0 no response");
    setupSlave(0, 32'h01, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0);
    pushWrite(ADDR_ARGUMENT, 32'h0);
    pushWrite(ADDR_COMMAND, 32'h0);
    pushRead(ADDR_CMD_EVT);
    pushWrite(ADDR_CMD_EVT, 32'h0);
    pushResult(128'h0, 5'h01, 1'b0);
    applyStimulus(6'd0, 32'h0, RSP_NONE, 2'b00);
    waitDone(200);

    $display("[TB] CMD55 poll timeout");
    setupSlave(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0);
    pushWrite(ADDR_ARGUMENT, 32'h0);
    pushWrite(ADDR_COMMAND, 32'h0000_3719);
    for (int i = 0; i < POLL_LIMIT; i++) pushRead(ADDR_CMD_EVT);
    pushWrite(ADDR_CMD_EVT, 32'h0);
    pushResult(128'h0, 5'h00, 1'b1);
    applyStimulus(6'd55, 32'h0, RSP_48, 2'b11);
    waitDone(200);

    $display("[TB] CMD17 status CC|EI");
    setupSlave(0, 32'h03, 0, 0, 0, 32'h0000_0900, 0, 0, 0);
    pushWrite(ADDR_ARGUMENT, 32'h0000_0200);
    pushWrite(ADDR_COMMAND, 32'h0000_1119);
    pushRead(ADDR_CMD_EVT);
    pushRead(ADDR_RESPONSE_0);
    pushWrite(ADDR_CMD_EVT, 32'h0);
    pushResult(128'h0000_0900, 5'h03, 1'b0);
    applyStimulus(6'd17, 32'h0000_0200, RSP_48, 2'b11);
    waitDone(200);
    checkOutput("doneLatency", doneCycle - acceptCycle, 11);

    $display("[TB] CMD7 busy type, status CTE only");
    setupSlave(0, 32'h04, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0);
    pushWrite(ADDR_ARGUMENT, 32'h1234_0000);
    pushWrite(ADDR_COMMAND, 32'h0000_071D);
    pushRead(ADDR_CMD_EVT);
    pushWrite(ADDR_CMD_EVT, 32'h0);
    pushResult(128'h0, 5'h04, 1'b0);
    applyStimulus(6'd7, 32'h1234_0000, RSP_48_BUSY, 2'b11);
    waitDone(200);

    $display("[TB] Reset during POLL with slow slave");
    setupSlave(4, 0, 0, 0, 0, 0, 0, 0, 0);
    pushWrite(ADDR_ARGUMENT, 32'hAAAA_0000);
    pushWrite(ADDR_COMMAND, 32'h0000_0D19);
    pushRead(ADDR_CMD_EVT);
    applyStimulus(6'd13, 32'hAAAA_0000, RSP_48, 2'b11);
    n = 0;
    while (!(wb_stb_o && !wb_we_o && wb_adr_o == ADDR_CMD_EVT) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachedPoll", wb_stb_o && wb_adr_o == ADDR_CMD_EVT, 1);
    repeat (2) @(negedge clk);
    checkOutput("stbHeldMidPoll", wb_stb_o, 1);
    startDone = doneCount;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midResetBus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, 0);
    checkOutput("midResetResult", {done, timeout, evt_status, rsp}, 0);
    txnQ.delete();
    resQ.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("readyAfterMidReset", cmd_ready, 1);
    repeat (30) @(negedge clk);
    checkOutput("noDoneAfterReset", doneCount - startDone, 0);

    $display("[TB] CMD0 after reset with two wait states");
    setupSlave(2, 32'h01, 0, 0, 0, 0, 0, 0, 0);
    pushWrite(ADDR_ARGUMENT, 32'h0);
    pushWrite(ADDR_COMMAND, 32'h0);
    pushRead(ADDR_CMD_EVT);
    pushWrite(ADDR_CMD_EVT, 32'h0);
    pushResult(128'h0, 5'h01, 1'b0);
    applyStimulus(6'd0, 32'h0, RSP_NONE, 2'b00);
    waitDone(300);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
